// File: rtl/serial_word_serializer.sv
// Parallel-in / serial-out word serializer with a one-entry holding buffer.
// Optional even parity bit per word when SERIALIZER_PARITY_EN is defined.
module serial_word_serializer #(
  parameter int W         = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic [W-1:0] din,
  input  logic         din_valid,
  output logic         din_ready,
  output logic         dout,
  output logic         dout_valid,
  output logic         busy
);

`ifdef SERIALIZER_PARITY_EN
  localparam int L = W + 1;
`else
  localparam int L = W;
`endif
  localparam int CW = $clog2(L);

  logic [W-1:0]  sh;
  logic [W-1:0]  hold;
  logic          hold_full;
  logic [CW-1:0] cnt;
`ifdef SERIALIZER_PARITY_EN
  logic          par;
`endif

  logic          hs;
  logic          last;
  logic          free;
  logic          load;
  logic [W-1:0]  nxt;

  function automatic logic head(input logic [W-1:0] w);
    return MSB_FIRST ? w[W-1] : w[0];
  endfunction

  function automatic logic [W-1:0] adv(input logic [W-1:0] w);
    return MSB_FIRST ? (w << 1) : (w >> 1);
  endfunction

  assign din_ready = !hold_full;
  assign hs        = din_valid && !hold_full;
  assign last      = dout_valid && (cnt == CW'(L - 1));
  assign free      = !dout_valid || last;
  assign load      = free && (hold_full || hs);
  assign nxt       = hold_full ? hold : din;
  assign busy      = dout_valid || hold_full;

  // Shifter: load a new word when free, otherwise emit the next bit.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sh         <= '0;
      cnt        <= '0;
      dout       <= 1'b0;
      dout_valid <= 1'b0;
`ifdef SERIALIZER_PARITY_EN
      par        <= 1'b0;
`endif
    end else if (load) begin
      dout       <= head(nxt);
      sh         <= adv(nxt);
      cnt        <= '0;
      dout_valid <= 1'b1;
`ifdef SERIALIZER_PARITY_EN
      par        <= ^nxt;
`endif
    end else if (free) begin
      dout       <= 1'b0;
      dout_valid <= 1'b0;
      cnt        <= '0;
    end else begin
      cnt <= cnt + 1'b1;
`ifdef SERIALIZER_PARITY_EN
      if (cnt == CW'(W - 1)) begin
        dout <= par;
      end else begin
        dout <= head(sh);
        sh   <= adv(sh);
      end
`else
      dout <= head(sh);
      sh   <= adv(sh);
`endif
    end
  end

  // Holding buffer: captures a word unless it bypasses into the shifter.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hold      <= '0;
      hold_full <= 1'b0;
    end else if (hs && !(free && !hold_full)) begin
      hold      <= din;
      hold_full <= 1'b1;
    end else if (free && hold_full) begin
      hold_full <= 1'b0;
    end
  end

endmodule
